// File: rtl/fp8_result_q.sv
// fp8_result_q: result/flag FIFO behind the fp8 unit with sticky flags and drop counter
module fp8_result_q #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_result,
    input  logic [4:0]               in_flags,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [7:0]               out_result,
    output logic [4:0]               out_flags,
    input  logic                     out_ready,
    output logic [4:0]               fflags,
    input  logic                     fflags_clr,
    output logic [CW-1:0]            drop_cnt,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [12:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          push, pop, drop;
    logic [CW-1:0] drop_base;
    assign in_ready   = count != (AW+1)'(DEPTH);
    assign out_valid  = count != '0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign drop       = in_valid && !in_ready;
    assign drop_base  = fflags_clr ? '0 : drop_cnt;
    assign out_result = out_valid ? mem[rp][7:0] : '0;
    assign out_flags  = out_valid ? mem[rp][12:8] : '0;
    // storage is not reset; out_valid gates what the consumer sees
    always_ff @(posedge clk)
        if (push) mem[wp] <= {in_flags, in_result};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            fflags   <= '0;
            drop_cnt <= '0;
        end else begin
            wp       <= push ? wp + 1'b1 : wp;
            rp       <= pop ? rp + 1'b1 : rp;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            fflags   <= (fflags_clr ? 5'd0 : fflags) | (push ? in_flags : 5'd0);
            drop_cnt <= (drop && drop_base != '1) ? drop_base + 1'b1 : drop_base;
        end
    end
endmodule

// File: tb/tb_fp8_result_q.sv
// tb_fp8_result_q: scoreboard bench for fp8_result_q (default CW and a CW=2 copy)
module tb_fp8_result_q;
    logic       clk = 0, reset = 0, in_valid = 0, out_ready = 0, fflags_clr = 0;
    logic [7:0] in_result = 0;
    logic [4:0] in_flags = 0;
    logic       in_ready, out_valid, in_ready2, out_valid2;
    logic [7:0] out_result, out_result2;
    logic [4:0] out_flags, out_flags2, fflags, fflags2;
    logic [7:0] drop_cnt;
    logic [1:0] drop_cnt2;
    logic [2:0] count, count2;
    int         vecs = 0, errs = 0, md1 = 0, md2 = 0;
    logic [4:0] mff = 0;
    logic [12:0] q[$];

    fp8_result_q u1 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result),
        .in_flags(in_flags), .in_ready(in_ready), .out_valid(out_valid), .out_result(out_result),
        .out_flags(out_flags), .out_ready(out_ready), .fflags(fflags), .fflags_clr(fflags_clr),
        .drop_cnt(drop_cnt), .count(count));
    fp8_result_q #(.CW(2)) u2 (.clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result),
        .in_flags(in_flags), .in_ready(in_ready2), .out_valid(out_valid2), .out_result(out_result2),
        .out_flags(out_flags2), .out_ready(out_ready), .fflags(fflags2), .fflags_clr(fflags_clr),
        .drop_cnt(drop_cnt2), .count(count2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        logic [12:0] head = q.size() != 0 ? q[0] : 13'd0;
        chk("count", 32'(count), q.size());
        chk("in_ready", 32'(in_ready), 32'(q.size() != 4));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("head", {out_flags, out_result}, head);
        chk("fflags", fflags, mff);
        chk("drop_cnt", drop_cnt, md1);
        chk("count2", 32'(count2), q.size());
        chk("head2", {out_flags2, out_result2}, head);
        chk("drop_cnt2", drop_cnt2, md2);
        chk("fflags2", fflags2, mff);
        chk("rdy2", {in_ready2, out_valid2}, {q.size() != 4, q.size() != 0});
    endtask

    task automatic cyc(input logic v, input logic [7:0] r, input logic [4:0] f,
                       input logic ordy, input logic clr);
        logic push, pop, drop;
        int b;
        @(negedge clk);
        check_state();
        in_valid = v; in_result = r; in_flags = f; out_ready = ordy; fflags_clr = clr;
        push = v && q.size() < 4;
        drop = v && q.size() >= 4;
        pop  = ordy && q.size() > 0;
        if (pop) chk("pop", {out_flags, out_result}, q.pop_front());
        if (push) q.push_back({f, r});
        mff = (clr ? 5'd0 : mff) | (push ? f : 5'd0);
        b = clr ? 0 : md1;
        md1 = (drop && b < 255) ? b + 1 : b;
        b = clr ? 0 : md2;
        md2 = (drop && b < 3) ? b + 1 : b;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 5'h00, ordy, 0);
    endtask

    initial begin
        #2 check_state();
        @(negedge clk) reset = 1;
        cyc(1, 8'h3C, 5'h01, 0, 0);
        idle(1, 0);
        chk("first_result", out_result, 8'h3C);
        chk("first_flags", out_flags, 5'h01);
        idle(2, 1);
        for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 5'h00, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'h14, 5'h00, 0, 0);
        cyc(1, 8'h14, 5'h00, 1, 0);
        idle(5, 1);
        chk("drop_after_full", drop_cnt, 8'd4);
        cyc(1, 8'h20, 5'h00, 0, 0);
        cyc(1, 8'h21, 5'h00, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 8'h30 + 8'(i), 5'h00, 1, 0);
        idle(3, 1);
        cyc(0, 8'h00, 5'h00, 1, 1);
        cyc(1, 8'h40, 5'h04, 1, 0);
        cyc(1, 8'h41, 5'h10, 1, 0);
        idle(1, 1);
        chk("fflags_acc", fflags, 5'h14);
        cyc(1, 8'h42, 5'h02, 1, 1);
        idle(1, 1);
        chk("fflags_clr_push", fflags, 5'h02);
        for (int i = 0; i < 4; i++) cyc(1, 8'h60 + 8'(i), 5'h08, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'h70, 5'h00, 0, 0);
        cyc(0, 8'h00, 5'h00, 1, 0);
        idle(1, 0);
        chk("drop5", drop_cnt, 8'd5);
        chk("drop5_sat", drop_cnt2, 2'd3);
        @(negedge clk);
        check_state();
        #2 reset = 0;
        #1;
        chk("rst_async", {out_valid, out_result, out_flags, in_ready, count}, {1'b0, 8'h00, 5'h00, 1'b1, 3'd0});
        chk("rst_cnt", {fflags, drop_cnt, drop_cnt2}, 0);
        q.delete(); mff = 0; md1 = 0; md2 = 0;
        in_valid = 0; out_ready = 0; fflags_clr = 0;
        @(posedge clk) #3 reset = 1;
        cyc(1, 8'h55, 5'h00, 0, 0);
        idle(1, 0);
        chk("after_rst", {out_valid, out_result, count}, {1'b1, 8'h55, 3'd1});
        idle(2, 1);
        check_state();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fp8_result_q.md
# fp8_result_q

Result/flag collection stage directly downstream of the `fp8` arithmetic unit. It captures each `result`/`flags` pair the unit produces into a DEPTH-entry first-in first-out buffer. It presents the pairs to the consumer over a valid/ready handshake. It also maintains sticky IEEE-style exception flags and a count of results lost to back-pressure.

## Interface

Parameters:
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two and at least 2.
- `CW`, default 8: width of the drop counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `in_valid` input 1: the fp8 unit presents a result this cycle.
- `in_result` input 8: fp8 result.
- `in_flags` input 5: exception flags from the unit, {NV, DZ, OF, UF, NX} as bits [4:0].
- `in_ready` output 1: an entry is free; the input is accepted when `in_valid && in_ready`.
- `out_valid` output 1: the head entry is valid.
- `out_result` output 8: result in the head entry.
- `out_flags` output 5: flags in the head entry.
- `out_ready` input 1: the consumer takes the head entry when `out_valid && out_ready`.
- `fflags` output 5: sticky OR of the flags of all accepted inputs.
- `fflags_clr` input 1: synchronous clear of `fflags` and `drop_cnt`.
- `drop_cnt` output CW: saturating count of cycles with `in_valid && !in_ready`.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation

- Storage is a circular buffer with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, plus `count`.
- Both pointers wrap from DEPTH-1 to 0.
- Occupancy states:
  - EMPTY: `count`=0.
  - PARTIAL: 0<`count`<DEPTH.
  - FULL: `count`=DEPTH.
- State transitions follow `count`.
- push = `in_valid && in_ready`:
  - Write `{in_flags, in_result}` at `wp`.
  - `wp`++.
- pop = `out_valid && out_ready`:
  - `rp`++.
- Count update on simultaneous push and pop: `count` unchanged. Otherwise +1 on push, -1 on pop.
- `in_ready` = (`count` != DEPTH). It is combinational from registered state only, so a pop in the same cycle does not free a slot. Input offered while FULL is never accepted, even with a simultaneous pop.
- `out_valid` = (`count` != 0).
- `out_result`/`out_flags` show the entry at `rp` (show-ahead). When EMPTY they read 0.
- `fflags`:
  - Next value = (`fflags_clr` ? 0 : `fflags`) | (push ? `in_flags` : 0).
  - Clear takes effect before accumulation, so a push in the clear cycle is retained.
- `drop_cnt`:
  - Next value = (`fflags_clr` ? 0 : `drop_cnt`) + drop, where drop = `in_valid && !in_ready`.
  - Saturates at 2^CW-1 and never wraps.
  - Clear plus drop in the same cycle yields 1.
- Popped entries are not zeroed; only pointer movement matters.

## Timing

- Reset values (asynchronous, on `reset`=0):
  - `wp`=`rp`=`count`=0.
  - `in_ready`=1.
  - `out_valid`=0, `out_result`=0, `out_flags`=0.
  - `fflags`=0, `drop_cnt`=0.
- Latency: an input accepted at edge N is visible on `out_*` after edge N (first cycle after) when the FIFO was EMPTY. There is no same-cycle pass-through.
- Throughput: one push and one pop per cycle is sustained in PARTIAL.
- `out_*` remain stable while `out_valid && !out_ready`.
- Reset asserted mid-operation discards all entries and counters at once. The first push after release is accepted in the first cycle with `reset`=1.
- `fflags` and `drop_cnt` update on the edge of the qualifying cycle and are visible the following cycle.

## Test plan

- Reset, then push 0x3C/flags 0x01 with `out_ready`=0 -> next cycle `out_valid`=1, `out_result`=0x3C, `out_flags`=0x01, `count`=1, `fflags`=0x01.
- Push 4 entries 0x10, 0x11, 0x12, 0x13 with `out_ready`=0 -> `count`=4, `in_ready`=0. Offer 0x14 for 3 cycles -> `drop_cnt`=3. Then drain -> outputs 0x10..0x13 in order, and 0x14 is never seen.
- FULL with `in_valid` and `out_ready` both 1 for one cycle -> pop of 0x10, input rejected, `count`=3, `drop_cnt`+1.
- PARTIAL streaming of 20 pushes/pops every cycle -> pointer wrap exercised, outputs in order with 1-cycle latency, `count` constant.
- Pushes with flags 0x04 then 0x10 -> `fflags`=0x14. Then `fflags_clr` with a simultaneous push of flags 0x02 -> `fflags`=0x02 and `drop_cnt`=0. With CW=2, 5 drops -> `drop_cnt`=3.
- Reset asserted asynchronously (mid-cycle) with `count`=3 -> all outputs 0 and `in_ready`=1 immediately. After release, push 0x55 -> it appears at the head alone.
